// File: rtl/cache_miss_sequencer.sv
// Sequencer for one direct-mapped cache and its backing memory: lookup, in-order block fill
// on a miss, single-cycle response, and saturating hit/miss counters.
module cache_miss_sequencer #(
    parameter int unsigned ADDRESSL  = 15,
    parameter int unsigned WORD      = 32,
    parameter int unsigned BLOCKSIZE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic [ADDRESSL-1:0] address,
    output logic                ready,
    output logic [WORD-1:0]     dataOut,
    output logic                busy,
    output logic                cRead,
    input  logic                cacheHit,
    input  logic [WORD-1:0]     cacheData,
    output logic                cWrite,
    output logic [ADDRESSL-1:0] cAddr,
    output logic [WORD-1:0]     cWrData,
    output logic                memRead,
    output logic [ADDRESSL-1:0] memAddr,
    input  logic [WORD-1:0]     memData,
    input  logic                memReady,
    output logic [ADDRESSL-1:0] numOfHits,
    output logic [ADDRESSL-1:0] numOfMisses
);
    localparam int unsigned OFFW = $clog2(BLOCKSIZE);

    typedef enum logic [1:0] {StIdle, StLookup, StFill, StRespond} state_e;

    state_e              state_q, state_d;
    logic [ADDRESSL-1:0] req_addr_q, req_addr_d;
    logic [OFFW-1:0]     cnt_q, cnt_d;
    logic [WORD-1:0]     data_q, data_d;
    logic [ADDRESSL-1:0] hits_q, hits_d;
    logic [ADDRESSL-1:0] misses_q, misses_d;

    assign memAddr     = {req_addr_q[ADDRESSL-1:OFFW], cnt_q};
    assign dataOut     = data_q;
    assign numOfHits   = hits_q;
    assign numOfMisses = misses_q;

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        hits_d     = hits_q;
        misses_d   = misses_q;
        ready      = 1'b0;
        busy       = (state_q != StIdle);
        cRead      = 1'b0;
        cWrite     = 1'b0;
        cAddr      = req_addr_q;
        cWrData    = '0;
        memRead    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    req_addr_d = address;
                    state_d    = StLookup;
                end
            end
            StLookup: begin
                cRead = 1'b1;
                if (cacheHit) begin
                    data_d  = cacheData;
                    hits_d  = (hits_q == '1) ? hits_q : hits_q + ADDRESSL'(1);
                    state_d = StRespond;
                end else begin
                    misses_d = (misses_q == '1) ? misses_q : misses_q + ADDRESSL'(1);
                    cnt_d    = '0;
                    state_d  = StFill;
                end
            end
            StFill: begin
                memRead = 1'b1;
                cAddr   = memAddr;
                if (memReady) begin
                    cWrite  = 1'b1;
                    cWrData = memData;
                    if (cnt_q == req_addr_q[OFFW-1:0]) begin
                        data_d = memData;
                    end
                    // BLOCKSIZE is a power of two, so the last word index is all-ones.
                    if (cnt_q == '1) begin
                        state_d = StRespond;
                    end else begin
                        cnt_d = cnt_q + OFFW'(1);
                    end
                end
            end
            StRespond: begin
                ready   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            req_addr_q <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            hits_q     <= '0;
            misses_q   <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            hits_q     <= hits_d;
            misses_q   <= misses_d;
        end
    end

endmodule
